// File: rtl/lose_screen_pixel_fetch.sv
// Scan-position to lose-screen ROM address fetch, with a 3-cycle aligned pipeline
// for the palette index and display timing, plus a frame-aligned overlay enable FSM.
module lose_screen_pixel_fetch #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 15,
  parameter int IDX_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lose,
  input  logic              restart,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  index,
  output logic              overlay_en,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    HIDDEN = 2'd0,
    ARMED  = 2'd1,
    SHOWN  = 2'd2
  } state_t;

  localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0] LP_IMG_W    = 10'(IMG_W);
  localparam logic [9:0] LP_IMG_H    = 10'(IMG_H);

  state_t r_state;
  state_t w_next_state;

  logic [9:0]        w_xs;
  logic [9:0]        w_ys;
  logic [ADDR_W-1:0] w_ys_ext;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_range;
  logic              w_frame_start;
  logic              w_ovl;

  logic              r_s1_inr, r_s1_ovl, r_s1_de, r_s1_hs, r_s1_vs;
  logic              r_s2_inr, r_s2_ovl, r_s2_de, r_s2_hs, r_s2_vs;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [IDX_W-1:0]  r_index;
  logic              r_ovl_en, r_de, r_hs, r_vs;

  assign w_xs = draw_x >> SCALE_SHIFT;
  assign w_ys = draw_y >> SCALE_SHIFT;

  // Image-bound terms keep the address legal even if timing parameters change.
  assign w_in_range = de_in && (draw_x < LP_H_ACTIVE) && (draw_y < LP_V_ACTIVE)
                      && (w_xs < LP_IMG_W) && (w_ys < LP_IMG_H);

  // y*160 as (y<<7)+(y<<5): the image row stride is fixed at 160.
  assign w_ys_ext = ADDR_W'(w_ys);
  assign w_addr   = (w_ys_ext << 7) + (w_ys_ext << 5) + ADDR_W'(w_xs);

  assign w_frame_start = (draw_x == 10'd0) && (draw_y == 10'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= HIDDEN;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (restart) begin
      w_next_state = HIDDEN;
    end else begin
      case (r_state)
        HIDDEN:  if (lose) w_next_state = ARMED;
        ARMED:   if (w_frame_start) w_next_state = SHOWN;
        SHOWN:   w_next_state = SHOWN;
        default: w_next_state = HIDDEN;
      endcase
    end
  end

  // The ARMED frame-start term makes pixel (0,0) the first overlaid pixel.
  always_comb begin
    w_ovl     = (r_state == SHOWN) || ((r_state == ARMED) && w_frame_start);
    dbg_state = r_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_s1_inr   <= 1'b0;
      r_s1_ovl   <= 1'b0;
      r_s1_de    <= 1'b0;
      r_s1_hs    <= 1'b1;
      r_s1_vs    <= 1'b1;
      r_s2_inr   <= 1'b0;
      r_s2_ovl   <= 1'b0;
      r_s2_de    <= 1'b0;
      r_s2_hs    <= 1'b1;
      r_s2_vs    <= 1'b1;
      r_index    <= '0;
      r_ovl_en   <= 1'b0;
      r_de       <= 1'b0;
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
    end else begin
      r_rom_addr <= w_in_range ? w_addr : '0;
      r_s1_inr   <= w_in_range;
      r_s1_ovl   <= w_ovl;
      r_s1_de    <= de_in;
      r_s1_hs    <= hs_in;
      r_s1_vs    <= vs_in;
      r_s2_inr   <= r_s1_inr;
      r_s2_ovl   <= r_s1_ovl;
      r_s2_de    <= r_s1_de;
      r_s2_hs    <= r_s1_hs;
      r_s2_vs    <= r_s1_vs;
      // rom_q now belongs to the same pixel as the stage-2 side-band.
      r_index    <= r_s2_inr ? rom_q : '0;
      r_ovl_en   <= r_s2_ovl && r_s2_inr;
      r_de       <= r_s2_de;
      r_hs       <= r_s2_hs;
      r_vs       <= r_s2_vs;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign index      = r_index;
  assign overlay_en = r_ovl_en;
  assign de_out     = r_de;
  assign hs_out     = r_hs;
  assign vs_out     = r_vs;

endmodule

// File: tb/tb_lose_screen_pixel_fetch.sv
// Directed table-driven bench for lose_screen_pixel_fetch with a synchronous ROM model
// and hand-written reset-mid-frame sequence.
module tb_lose_screen_pixel_fetch;

  localparam logic [1:0] ST_H = 2'd0;
  localparam logic [1:0] ST_A = 2'd1;
  localparam logic [1:0] ST_S = 2'd2;

  typedef struct {
    logic        lose;
    logic        restart;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        hs;
    logic        vs;
    logic [14:0] exp_addr;
    logic        exp_inr;
    logic        exp_ovl;
    logic [1:0]  exp_state;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        lose, restart;
  logic [9:0]  draw_x, draw_y;
  logic        de_in, hs_in, vs_in;
  logic [14:0] rom_addr;
  logic [4:0]  rom_q = 5'd0;
  logic [4:0]  index;
  logic        overlay_en, de_out, hs_out, vs_out;
  logic [1:0]  dbg_state;

  int applied    = 0;
  int miscompares = 0;
  vec_t vecs[$];

  lose_screen_pixel_fetch dut (
    .clk(clk), .reset(reset), .lose(lose), .restart(restart),
    .draw_x(draw_x), .draw_y(draw_y), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .rom_addr(rom_addr), .rom_q(rom_q), .index(index), .overlay_en(overlay_en),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] rom_f(input logic [14:0] a);
    return a[4:0] ^ a[9:5] ^ a[14:10] ^ 5'd7;
  endfunction

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_q <= rom_f(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic l, input logic r, input int x, input int y,
                     input logic de, input logic hs, input logic vs,
                     input int addr, input logic inr, input logic ovl, input logic [1:0] st);
    vec_t v;
    v.lose = l; v.restart = r; v.x = 10'(x); v.y = 10'(y);
    v.de = de; v.hs = hs; v.vs = vs;
    v.exp_addr = 15'(addr); v.exp_inr = inr; v.exp_ovl = ovl; v.exp_state = st;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic l, input logic r, input int x, input int y,
                       input logic de, input logic hs, input logic vs);
    lose = l; restart = r; draw_x = 10'(x); draw_y = 10'(y);
    de_in = de; hs_in = hs; vs_in = vs;
  endtask

  initial begin
    vec_t v;
    logic [4:0] exp_idx;

    //  lose rst  x    y   de hs vs  addr  inr ovl state-after
    add(0, 0,   0,   5, 1, 1, 1,   160, 1, 0, ST_H);
    add(0, 0,   1,   5, 1, 1, 1,   160, 1, 0, ST_H);
    add(0, 0,   4,   5, 1, 1, 1,   161, 1, 0, ST_H);
    add(0, 0,  13,   5, 1, 1, 1,   163, 1, 0, ST_H);
    add(0, 0, 639,   5, 1, 1, 1,   319, 1, 0, ST_H);
    add(0, 0, 650,   5, 0, 0, 1,     0, 0, 0, ST_H);
    add(0, 0,  10,  10, 0, 1, 0,     0, 0, 0, ST_H);
    add(0, 0, 700,   5, 1, 1, 1,     0, 0, 0, ST_H);
    add(1, 0, 300, 200, 1, 1, 1,  8075, 1, 0, ST_A);
    add(0, 0, 301, 200, 1, 1, 1,  8075, 1, 0, ST_A);
    add(0, 0, 639, 479, 1, 1, 1, 19199, 1, 0, ST_A);
    add(0, 0,   0, 500, 0, 1, 0,     0, 0, 0, ST_A);
    add(0, 0,   0,   0, 1, 1, 1,     0, 1, 1, ST_S);
    add(0, 0,   1,   0, 1, 1, 1,     0, 1, 1, ST_S);
    add(0, 0,   5,   9, 1, 1, 1,   321, 1, 1, ST_S);
    add(1, 0,   8,   9, 1, 1, 1,   322, 1, 1, ST_S);
    add(0, 0, 639, 479, 1, 1, 1, 19199, 1, 1, ST_S);
    add(0, 0, 700,  10, 1, 0, 1,     0, 0, 0, ST_S);
    add(0, 1, 100,  50, 1, 1, 1,  1945, 1, 1, ST_H);
    add(0, 0, 101,  50, 1, 1, 1,  1945, 1, 0, ST_H);
    add(0, 0,   0,   0, 1, 1, 1,     0, 1, 0, ST_H);
    add(1, 0,   0,   0, 1, 1, 1,     0, 1, 0, ST_A);
    add(0, 0,   1,   0, 1, 1, 1,     0, 1, 0, ST_A);
    add(0, 0,   0,   0, 1, 1, 1,     0, 1, 1, ST_S);
    add(1, 1,   2,   0, 1, 1, 1,     0, 1, 1, ST_H);
    add(0, 0,   3,   0, 1, 1, 1,     0, 1, 0, ST_H);
    add(0, 0,   0,   0, 1, 1, 1,     0, 1, 0, ST_H);
    add(1, 0,   4,   4, 1, 1, 1,   161, 1, 0, ST_A);
    add(0, 1,   5,   4, 1, 1, 1,   161, 1, 0, ST_H);
    add(0, 0,   0,   0, 1, 1, 1,     0, 1, 0, ST_H);
    add(0, 0,  12,  16, 1, 0, 0,   643, 1, 0, ST_H);
    add(0, 0, 700, 500, 0, 1, 1,     0, 0, 0, ST_H);
    add(0, 0, 700, 500, 0, 1, 1,     0, 0, 0, ST_H);
    add(0, 0, 700, 500, 0, 1, 1,     0, 0, 0, ST_H);

    // Clock/reset
    reset = 1'b1;
    drive(0, 0, 700, 500, 0, 1, 1);
    repeat (3) @(negedge clk);
    check("reset rom_addr", 32'(rom_addr), 0);
    check("reset index", 32'(index), 0);
    check("reset overlay_en", 32'(overlay_en), 0);
    check("reset de_out", 32'(de_out), 0);
    check("reset hs_out", 32'(hs_out), 1);
    check("reset vs_out", 32'(vs_out), 1);
    check("reset state", 32'(dbg_state), 32'(ST_H));
    reset = 1'b0;

    // Streamed table: rom_addr/state checked 1 cycle after a row, outputs 3 cycles after.
    for (int c = 0; c < vecs.size(); c++) begin
      @(negedge clk);
      if (c >= 1) begin
        v = vecs[c-1];
        check($sformatf("row%0d rom_addr", c-1), 32'(rom_addr), 32'(v.exp_addr));
        check($sformatf("row%0d state", c-1), 32'(dbg_state), 32'(v.exp_state));
      end
      if (c >= 3) begin
        v = vecs[c-3];
        exp_idx = v.exp_inr ? rom_f(v.exp_addr) : 5'd0;
        check($sformatf("row%0d index", c-3), 32'(index), 32'(exp_idx));
        check($sformatf("row%0d overlay_en", c-3), 32'(overlay_en), 32'(v.exp_ovl));
        check($sformatf("row%0d de_out", c-3), 32'(de_out), 32'(v.de));
        check($sformatf("row%0d hs_out", c-3), 32'(hs_out), 32'(v.hs));
        check($sformatf("row%0d vs_out", c-3), 32'(vs_out), 32'(v.vs));
      end
      v = vecs[c];
      drive(v.lose, v.restart, int'(v.x), int'(v.y), v.de, v.hs, v.vs);
    end

    // Reset asserted mid-frame while the overlay is armed.
    @(negedge clk); drive(1, 0, 300, 200, 1, 1, 1);
    @(negedge clk); drive(0, 0, 301, 200, 1, 1, 1);
    @(negedge clk); drive(0, 0, 302, 200, 1, 1, 1);
    @(negedge clk); drive(0, 0, 303, 200, 1, 1, 1);
    @(negedge clk);
    check("pre-reset state armed", 32'(dbg_state), 32'(ST_A));
    check("pre-reset de_out", 32'(de_out), 1);
    check("pre-reset rom_addr", 32'(rom_addr), 8075);
    #2 reset = 1'b1;
    #1;
    check("async rom_addr", 32'(rom_addr), 0);
    check("async index", 32'(index), 0);
    check("async overlay_en", 32'(overlay_en), 0);
    check("async de_out", 32'(de_out), 0);
    check("async hs_out", 32'(hs_out), 1);
    check("async vs_out", 32'(vs_out), 1);
    check("async state", 32'(dbg_state), 32'(ST_H));
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 1, 1);
    repeat (3) @(negedge clk);
    check("post-reset de_out", 32'(de_out), 1);
    check("post-reset index", 32'(index), 32'(rom_f(15'd0)));
    check("post-reset overlay_en", 32'(overlay_en), 0);

    // Abbreviated frame pair: the pending lose must not survive reset.
    for (int i = 0; i < 48; i++) begin
      drive(0, 0, (i % 24) * 7, (i / 24) * 0, 1, 1, 1);
      @(negedge clk);
      check($sformatf("post-reset pixel%0d overlay_en", i), 32'(overlay_en), 0);
      check($sformatf("post-reset pixel%0d state", i), 32'(dbg_state), 32'(ST_H));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
